// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with valid/ready handshake on both sides.
// Define ALU_SPLIT_ADD_EN to run add-class ops through a half-width adder over two cycles.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      control_signal,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            branch_taken
);
  typedef enum logic [1:0] {IDLE, CALC_HI, VALID} state_t;
  state_t state, state_nxt;

  logic            accept, add_cls, sub, split_op, br_c, add_br;
  logic [XLEN-1:0] b_eff, res_c, add_res;

  // Signed less-than comes from the difference sign corrected by overflow.
  function automatic logic branch_eval(input logic [3:0] code, input logic a_msb,
                                       input logic b_msb, input logic d_msb, input logic d_zero);
    logic lt;
    lt = d_msb ^ ((a_msb ^ b_msb) & (d_msb ^ a_msb));
    case (code)
      4'b0110: branch_eval = d_zero;
      4'b0100: branch_eval = lt;
      4'b0101: branch_eval = !lt;
      default: branch_eval = 1'b0;
    endcase
  endfunction

  assign add_cls   = control_signal inside {4'b0010, 4'b0110, 4'b0100, 4'b0101};
  assign sub       = control_signal[2];
  assign b_eff     = sub ? ~op_b : op_b;
  assign in_ready  = !reset && (state == IDLE || (state == VALID && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == VALID);

`ifdef ALU_SPLIT_ADD_EN
  localparam int H = XLEN / 2;
  logic [H:0]      lo_c;
  logic [H-1:0]    lo_q, a_hi_q, bx_hi_q, hi_c;
  logic            cy_q;
  logic [3:0]      code_q;
  logic [XLEN-1:0] sum_s;
  logic            br_s;

  assign split_op = add_cls;
  assign add_res  = '0;
  assign add_br   = 1'b0;
  assign lo_c     = {1'b0, op_a[H-1:0]} + {1'b0, b_eff[H-1:0]} + {{H{1'b0}}, sub};

  // Low half and its carry are captured on accept; the high half finishes in CALC_HI.
  always_ff @(posedge clk) begin
    if (accept) begin
      lo_q    <= lo_c[H-1:0];
      cy_q    <= lo_c[H];
      a_hi_q  <= op_a[XLEN-1:H];
      bx_hi_q <= b_eff[XLEN-1:H];
      code_q  <= control_signal;
    end
  end

  assign hi_c  = a_hi_q + bx_hi_q + {{(H-1){1'b0}}, cy_q};
  assign sum_s = {hi_c, lo_q};
  assign br_s  = branch_eval(code_q, a_hi_q[H-1], bx_hi_q[H-1] ^ code_q[2],
                             hi_c[H-1], sum_s == '0);
`else
  logic [XLEN-1:0] sum_full;

  assign split_op = 1'b0;
  assign sum_full = op_a + b_eff + {{(XLEN-1){1'b0}}, sub};
  assign add_res  = sum_full;
  assign add_br   = branch_eval(control_signal, op_a[XLEN-1], op_b[XLEN-1],
                                sum_full[XLEN-1], sum_full == '0);
`endif

  always_comb begin
    res_c = '0;
    br_c  = 1'b0;
    case (control_signal)
      4'b0000: res_c = op_a & op_b;
      4'b0001: res_c = op_a | op_b;
      4'b0010, 4'b0110, 4'b0100, 4'b0101: begin
        res_c = add_res;
        br_c  = add_br;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = split_op ? CALC_HI : VALID;
      CALC_HI: state_nxt = VALID;
      VALID:   if (out_ready) state_nxt = in_valid ? (split_op ? CALC_HI : VALID) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Outputs only change on a single-cycle accept or at the end of CALC_HI.
  always_ff @(posedge clk) begin
    if (reset) begin
      result       <= '0;
      zero         <= 1'b0;
      branch_taken <= 1'b0;
    end else if (accept && !split_op) begin
      result       <= res_c;
      zero         <= (res_c == '0);
      branch_taken <= br_c;
`ifdef ALU_SPLIT_ADD_EN
    end else if (state == CALC_HI) begin
      result       <= sum_s;
      zero         <= (sum_s == '0);
      branch_taken <= br_s;
`endif
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results queued at accept, compared on consume.
module tb_alu_exec_unit;
  localparam int XLEN = 32;
`ifdef ALU_SPLIT_ADD_EN
  localparam int SPLIT = 1;
`else
  localparam int SPLIT = 0;
`endif

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            z;
    logic            br;
  } exp_t;

  logic            clk = 0, reset = 1, in_valid = 0, in_ready, out_valid, zero, branch_taken;
  logic            or_man = 0, rand_bp = 0, bp_rand = 0, out_ready;
  logic [3:0]      control_signal = 0;
  logic [XLEN-1:0] op_a = 0, op_b = 0, result;
  int              n_tests = 0, n_fail = 0, cyc = 0;
  exp_t            sb[$];

  assign out_ready = rand_bp ? bp_rand : or_man;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .control_signal(control_signal), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .branch_taken(branch_taken)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1 bp_rand = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    exp_t e;
    e.res = '0;
    e.br  = 1'b0;
    case (c)
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      4'b0010: e.res = a + b;
      4'b0110: begin e.res = a - b; e.br = (a == b); end
      4'b0100: begin e.res = a - b; e.br = ($signed(a) < $signed(b)); end
      4'b0101: begin e.res = a - b; e.br = ($signed(a) >= $signed(b)); end
      default: ;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic bit is_add(input logic [3:0] c);
    return c inside {4'b0010, 4'b0110, 4'b0100, 4'b0101};
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("zero", 32'(zero), 32'(e.z));
        chk("branch", 32'(branch_taken), 32'(e.br));
      end
    end
  end

  // Present an op, wait (bounded) for the accept edge, optionally queue its expectation.
  task automatic issue(input logic [3:0] c, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input bit push);
    bit acc = 0;
    in_valid = 1; control_signal = c; op_a = a; op_b = b;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    chk("accept", 32'(acc), 1);
    if (acc && push) sb.push_back(model(c, a, b));
    in_valid = 0;
  endtask

  task automatic lat_check(input string tag, input logic [3:0] c, input logic [XLEN-1:0] a,
                           input logic [XLEN-1:0] b, input int lat);
    issue(c, a, b, 1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk); chk(tag, 32'(out_valid), 32'(k == lat));
      @(posedge clk); #1;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("drained", 32'(sb.size()), 0);
  endtask

  function automatic logic [3:0] rnd_code();
    logic [3:0] t[8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0100, 4'b0101, 4'b0011, 4'b1111};
    return t[$urandom_range(0, 7)];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, exp_cyc;
    exp_t e1, e2;
    logic [3:0] c;
    logic [XLEN-1:0] a, b;

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk); chk("rst_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("rst_in_ready_after", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_result", result, 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_branch", 32'(branch_taken), 0);
    @(posedge clk); #1 or_man = 1;

    // Directed ops with latency checks
    lat_check("lat_and", 4'b0000, 32'h0000_00F0, 32'h0000_0F0F, 1);
    lat_check("lat_add", 4'b0010, 32'h0000_FFFF, 32'h0000_0001, 1 + SPLIT);
    issue(4'b0100, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    issue(4'b0101, 32'hFFFF_FFFF, 32'h0000_0001, 1);
    issue(4'b0100, 32'h8000_0000, 32'h7FFF_FFFF, 1);
    issue(4'b0101, 32'h7FFF_FFFF, 32'h8000_0000, 1);
    issue(4'b0110, 32'h1234_5678, 32'h1234_5678, 1);
    issue(4'b0110, 32'h1234_5678, 32'h1234_5679, 1);
    issue(4'b0011, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1);
    issue(4'b0001, 32'hA5A5_0000, 32'h0000_5A5A, 1);
    drain();

    // Back-to-back throughput with out_ready held high
    t0 = cyc; exp_cyc = 0;
    for (int i = 0; i < 16; i++) begin
      c = rnd_code(); a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (i > 0 && SPLIT != 0 && is_add(control_signal)) exp_cyc++;
      exp_cyc++;
      issue(c, a, b, 1);
    end
    chk("throughput", 32'(cyc - t0), 32'(exp_cyc));
    drain();

    // Backpressure: hold 3 cycles, then consume and accept on the same edge
    or_man = 0;
    e1 = model(4'b0010, 32'h0000_FFFF, 32'h0000_0001);
    issue(4'b0010, 32'h0000_FFFF, 32'h0000_0001, 1);
    for (int i = 0; i < 8 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    in_valid = 1; control_signal = 4'b0001; op_a = 32'h0F00_0000; op_b = 32'h0000_00F0;
    e2 = model(4'b0001, 32'h0F00_0000, 32'h0000_00F0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_in_ready", 32'(in_ready), 0);
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_result", result, e1.res);
      chk("hold_zero", 32'(zero), 32'(e1.z));
      @(posedge clk); #1;
    end
    or_man = 1;
    @(negedge clk); chk("release_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    sb.push_back(e2);
    in_valid = 0;
    @(negedge clk);
    chk("new_valid", 32'(out_valid), 1);
    chk("new_result", result, e2.res);
    @(posedge clk); #1;
    drain();

    // Random backpressure
    rand_bp = 1;
    for (int i = 0; i < 30; i++) begin
      a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      issue(rnd_code(), a, b, 1);
    end
    rand_bp = 0;
    drain();

    // Reset aborts an op in flight (CALC_HI in split build, VALID otherwise)
    or_man = 0;
    issue(4'b0010, 32'h1111_1111, 32'h2222_2222, 0);
    reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    chk("abort_result", result, 0);
    chk("abort_zero", 32'(zero), 0);
    chk("abort_branch", 32'(branch_taken), 0);
    @(posedge clk); #1;
    @(negedge clk); chk("abort_stays_idle", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
